// File: rtl/pu_sequencer_pkg.sv
// Shared types and widths for the PU layer sequencer.
package pu_sequencer_pkg;

    localparam int unsigned LANES  = 8;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = LANES * BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/pu_seq_addr_gen.sv
// Chunk/neuron/weight-address counters for the layer walk, with first/last flags.
module pu_seq_addr_gen #(
    parameter int unsigned NCHUNK = 4,
    parameter int unsigned NW     = 6,
    parameter int unsigned XAW    = 2,
    parameter int unsigned WAW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           advance,
    input  logic [NW-1:0]  n_neurons,
    output logic [XAW-1:0] x_addr,
    output logic [WAW-1:0] w_addr,
    output logic [NW-1:0]  b_addr,
    output logic           first_c,
    output logic           last_c,
    output logic           final_c
);

    logic [NW-1:0] n_last;

    assign first_c = (x_addr == '0);
    assign last_c  = (x_addr == XAW'(NCHUNK - 1));
    assign final_c = last_c && (b_addr == n_last);

    // Chunk is the inner loop; w_addr simply counts so no multiply is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_addr <= '0;
            w_addr <= '0;
            b_addr <= '0;
            n_last <= '0;
        end else if (load) begin
            x_addr <= '0;
            w_addr <= '0;
            b_addr <= '0;
            n_last <= n_neurons - NW'(1);
        end else if (advance) begin
            w_addr <= w_addr + WAW'(1);
            if (last_c) begin
                x_addr <= '0;
                b_addr <= b_addr + NW'(1);
            end else begin
                x_addr <= x_addr + XAW'(1);
            end
        end
    end

endmodule

// File: rtl/pu_sequencer.sv
// Walks one PU through a layer: issues memory reads, feeds operands, captures activations.
module pu_sequencer
    import pu_sequencer_pkg::*;
#(
    parameter  int unsigned NCHUNK = 4,
    parameter  int unsigned NW     = 6,
    localparam int unsigned XAW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1,
    localparam int unsigned WAW    = NW + XAW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NW-1:0]     n_neurons,
    output logic              busy,
    output logic              done,
    output logic [XAW-1:0]    x_addr,
    output logic [WAW-1:0]    w_addr,
    output logic [NW-1:0]     b_addr,
    input  logic [WORD_W-1:0] x_rdata,
    input  logic [WORD_W-1:0] w_rdata,
    input  logic [BYTE_W-1:0] b_rdata,
    output logic [WORD_W-1:0] pu_x,
    output logic [WORD_W-1:0] pu_w,
    output logic [BYTE_W-1:0] pu_bias,
    output logic              pu_isfirst,
    input  logic [BYTE_W-1:0] pu_out,
    output logic              res_valid,
    output logic [NW-1:0]     res_idx,
    output logic [BYTE_W-1:0] res_data
);

    state_t        state;
    state_t        state_next;
    logic          drain_cnt;
    logic          load_c;
    logic          advance_c;
    logic          first_c;
    logic          last_c;
    logic          final_c;

    logic          s1_valid;
    logic          s1_first;
    logic          s1_last;
    logic [NW-1:0] s1_idx;
    logic          s2_valid;
    logic          s2_last;
    logic [NW-1:0] s2_idx;

    pu_seq_addr_gen #(
        .NCHUNK (NCHUNK),
        .NW     (NW),
        .XAW    (XAW),
        .WAW    (WAW)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load_c),
        .advance   (advance_c),
        .n_neurons (n_neurons),
        .x_addr    (x_addr),
        .w_addr    (w_addr),
        .b_addr    (b_addr),
        .first_c   (first_c),
        .last_c    (last_c),
        .final_c   (final_c)
    );

    // Next-state and counter controls.
    always_comb begin
        state_next = state;
        load_c     = 1'b0;
        advance_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (n_neurons != '0) begin
                        state_next = ST_ISSUE;
                        load_c     = 1'b1;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                if (final_c) begin
                    state_next = ST_DRAIN;
                end else begin
                    advance_c = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register; busy/done are registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            drain_cnt <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == ST_DRAIN) && !drain_cnt;
            busy      <= (state_next != ST_IDLE);
            done      <= (state_next == ST_DONE);
        end
    end

    // Operand pipeline; bubbles present zero operands with isfirst set so the
    // PU accumulator restarts cleanly at the next neuron.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_first   <= 1'b0;
            s1_last    <= 1'b0;
            s1_idx     <= '0;
            s2_valid   <= 1'b0;
            s2_last    <= 1'b0;
            s2_idx     <= '0;
            pu_x       <= '0;
            pu_w       <= '0;
            pu_bias    <= '0;
            pu_isfirst <= 1'b1;
            res_valid  <= 1'b0;
            res_idx    <= '0;
            res_data   <= '0;
        end else begin
            s1_valid <= (state == ST_ISSUE);
            s1_first <= first_c;
            s1_last  <= last_c;
            s1_idx   <= b_addr;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_idx   <= s1_idx;
            if (s1_valid) begin
                pu_x       <= x_rdata;
                pu_w       <= w_rdata;
                pu_bias    <= b_rdata;
                pu_isfirst <= s1_first;
            end else begin
                pu_x       <= '0;
                pu_w       <= '0;
                pu_bias    <= '0;
                pu_isfirst <= 1'b1;
            end
            res_valid <= s2_valid && s2_last;
            if (s2_valid && s2_last) begin
                res_data <= pu_out;
                res_idx  <= s2_idx;
            end
        end
    end

endmodule

// File: tb/tb_pu_sequencer.sv
// Self-checking bench: sequencer driving a behavioural PU and synchronous memories.
module tb_pu_sequencer;

    localparam int unsigned NCHUNK = 4;
    localparam int unsigned NW     = 6;
    localparam int unsigned XAW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned WAW    = NW + XAW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [NW-1:0]  n_neurons;
    logic           busy, done;
    logic [XAW-1:0] x_addr;
    logic [WAW-1:0] w_addr;
    logic [NW-1:0]  b_addr;
    logic [63:0]    x_rdata, w_rdata;
    logic [7:0]     b_rdata;
    logic [63:0]    pu_x, pu_w;
    logic [7:0]     pu_bias;
    logic           pu_isfirst;
    logic [7:0]     pu_out;
    logic           res_valid;
    logic [NW-1:0]  res_idx;
    logic [7:0]     res_data;

    pu_sequencer #(.NCHUNK(NCHUNK), .NW(NW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_neurons(n_neurons),
        .busy(busy), .done(done), .x_addr(x_addr), .w_addr(w_addr), .b_addr(b_addr),
        .x_rdata(x_rdata), .w_rdata(w_rdata), .b_rdata(b_rdata),
        .pu_x(pu_x), .pu_w(pu_w), .pu_bias(pu_bias), .pu_isfirst(pu_isfirst),
        .pu_out(pu_out), .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data)
    );

    always #5 clk = ~clk;

    logic [63:0] xmem [NCHUNK];
    logic [63:0] wmem [2**WAW];
    logic [7:0]  bmem [2**NW];

    always @(posedge clk) begin
        x_rdata <= xmem[x_addr];
        w_rdata <= wmem[w_addr];
        b_rdata <= bmem[b_addr];
    end

    function automatic int sm(input logic [7:0] b);
        return b[7] ? -int'(b[6:0]) : int'(b[6:0]);
    endfunction

    // Behavioural PU: sign-magnitude MAC, bias scaled by 2^12, ReLU, >>12, clamp to 255.
    int acc, pu_sum;
    always_comb begin
        pu_sum = pu_isfirst ? sm(pu_bias) * 4096 : acc;
        for (int l = 0; l < 8; l++) pu_sum = pu_sum + sm(pu_x[8*l +: 8]) * sm(pu_w[8*l +: 8]);
        if (pu_sum < 0) pu_out = 8'd0;
        else if ((pu_sum >>> 12) > 255) pu_out = 8'd255;
        else pu_out = 8'(pu_sum >>> 12);
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= 0;
        else acc <= pu_sum;
    end

    // Whole-neuron reference: bias plus full dot product, then activation.
    function automatic logic [7:0] ref_neuron(input int k);
        longint s;
        s = longint'(sm(bmem[k])) * 4096;
        for (int c = 0; c < int'(NCHUNK); c++)
            for (int l = 0; l < 8; l++)
                s += longint'(sm(xmem[c][8*l +: 8]) * sm(wmem[k*int'(NCHUNK)+c][8*l +: 8]));
        if (s < 0) return 8'd0;
        s = s / 4096;
        return (s > 255) ? 8'd255 : 8'(s);
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Per-layer observations.
    int         res_cnt, busy_cnt, done_cyc, addr_bad;
    logic       timed_out;
    int         got_idx  [64];
    logic [7:0] got_data [64];
    int         got_cyc  [64];
    logic [7:0] texp     [64];

    task automatic run_layer(input int n, input logic hold_start);
        logic seen;
        res_cnt = 0; busy_cnt = 0; done_cyc = -1; addr_bad = 0; seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        n_neurons = NW'(n);
        for (int cyc = 1; cyc <= n * int'(NCHUNK) + 10 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = hold_start;
                n_neurons = NW'($urandom);
            end
            if (busy) busy_cnt++;
            if (cyc <= n * int'(NCHUNK)) begin
                if (x_addr != XAW'((cyc - 1) % int'(NCHUNK)) || w_addr != WAW'(cyc - 1) ||
                    b_addr != NW'((cyc - 1) / int'(NCHUNK)))
                    addr_bad++;
            end
            if (res_valid && res_cnt < 64) begin
                got_idx[res_cnt]  = int'(res_idx);
                got_data[res_cnt] = res_data;
                got_cyc[res_cnt]  = cyc;
                res_cnt++;
            end
            if (done) begin
                done_cyc = cyc;
                seen = 1'b1;
            end
        end
        timed_out = !seen;
    endtask

    task automatic check_layer(input string tag, input int n);
        int last_cyc;
        last_cyc = (n == 0) ? 1 : n * int'(NCHUNK) + 3;
        chk({tag, ".timeout"}, longint'(timed_out), 0);
        chk({tag, ".res_count"}, res_cnt, n);
        for (int k = 0; k < res_cnt && k < n; k++) begin
            chk($sformatf("%s.idx[%0d]", tag, k), got_idx[k], k);
            chk($sformatf("%s.data[%0d]", tag, k), got_data[k], texp[k]);
            chk($sformatf("%s.res_cycle[%0d]", tag, k), got_cyc[k], (k + 1) * int'(NCHUNK) + 3);
        end
        chk({tag, ".done_cycle"}, done_cyc, last_cyc);
        chk({tag, ".busy_cycles"}, busy_cnt, last_cyc);
        if (n > 0) chk({tag, ".addr_seq"}, addr_bad, 0);
    endtask

    task automatic fill_uniform(input logic [7:0] xb, input int wmag, input logic wneg,
                                input bit wstep, input logic [7:0] bias);
        logic [7:0] wb;
        for (int c = 0; c < int'(NCHUNK); c++) xmem[c] = {8{xb}};
        for (int k = 0; k < 2**NW; k++) begin
            wb = {wneg, 7'(wstep ? wmag * (k + 1) : wmag)};
            for (int c = 0; c < int'(NCHUNK); c++) wmem[k*int'(NCHUNK)+c] = {8{wb}};
            bmem[k] = bias;
        end
    endtask

    task automatic fill_random();
        for (int c = 0; c < int'(NCHUNK); c++) xmem[c] = {$urandom, $urandom};
        for (int i = 0; i < 2**WAW; i++) wmem[i] = {$urandom, $urandom};
        for (int k = 0; k < 2**NW; k++) bmem[k] = 8'($urandom);
        for (int k = 0; k < 64; k++) texp[k] = ref_neuron(k);
    endtask

    typedef struct {
        int         n;
        logic [7:0] xb;
        int         wmag;
        logic       wneg;
        bit         wstep;
        logic [7:0] bias;
        logic [7:0] e0, e1, e2;
    } vec_t;

    vec_t tab [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [XAW-1:0] sx;
        logic [WAW-1:0] sw;
        logic [NW-1:0]  sb;

        tab[0] = '{1, 8'h10, 64, 1'b0, 1'b0, 8'h00, 8'd8,  8'd0,  8'd0};
        tab[1] = '{1, 8'h10, 64, 1'b1, 1'b0, 8'h00, 8'd0,  8'd0,  8'd0};
        tab[2] = '{3, 8'h20, 32, 1'b0, 1'b1, 8'h00, 8'd8,  8'd16, 8'd24};
        tab[3] = '{1, 8'h10, 64, 1'b0, 1'b0, 8'h03, 8'd11, 8'd0,  8'd0};
        tab[4] = '{2, 8'h10, 64, 1'b0, 1'b0, 8'h85, 8'd3,  8'd3,  8'd0};

        rst_n = 1'b0; start = 1'b0; n_neurons = '0;
        fill_uniform(8'h00, 0, 1'b0, 1'b0, 8'h00);
        #12;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.res_valid", res_valid, 0);
        chk("rst.res", {res_idx, res_data}, 0);
        chk("rst.addr", {x_addr, w_addr, b_addr}, 0);
        chk("rst.pu_ops", (pu_x != '0) || (pu_w != '0) || (pu_bias != '0), 0);
        chk("rst.pu_isfirst", pu_isfirst, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        for (int v = 0; v < 5; v++) begin
            fill_uniform(tab[v].xb, tab[v].wmag, tab[v].wneg, tab[v].wstep, tab[v].bias);
            texp[0] = tab[v].e0; texp[1] = tab[v].e1; texp[2] = tab[v].e2;
            run_layer(tab[v].n, 1'b0);
            check_layer($sformatf("vec%0d", v), tab[v].n);
        end

        // Empty layer: immediate done, addresses left alone.
        sx = x_addr; sw = w_addr; sb = b_addr;
        run_layer(0, 1'b0);
        check_layer("empty", 0);
        chk("empty.addr_hold", {x_addr, w_addr, b_addr}, {sx, sw, sb});

        // Back-to-back layers with start held; big accumulator first.
        fill_uniform(8'h7F, 127, 1'b0, 1'b0, 8'h7F);
        for (int k = 0; k < 2; k++) texp[k] = 8'd253;
        run_layer(2, 1'b1);
        check_layer("b2b_a", 2);
        chk("b2b.idle_gap_busy", busy, 1);
        fill_uniform(8'h10, 64, 1'b0, 1'b0, 8'h00);
        texp[0] = 8'd8;
        run_layer(1, 1'b0);
        check_layer("b2b_b", 1);

        // Reset while issuing neuron 1 of 3.
        fill_random();
        @(negedge clk);
        start = 1'b1; n_neurons = NW'(3);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && b_addr != NW'(1); i++) @(negedge clk);
        chk("midrst.reached_n1", b_addr, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.busy", busy, 0);
        chk("midrst.addr", {x_addr, w_addr, b_addr}, 0);
        chk("midrst.pu_isfirst", pu_isfirst, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst.no_done", done | res_valid, 0);
        end
        rst_n = 1'b1;
        run_layer(3, 1'b0);
        check_layer("midrst_fresh", 3);

        // Randomized layers against the reference model.
        for (int r = 0; r < 12; r++) begin
            int n;
            n = (r == 5) ? 0 : int'($urandom_range(1, 6));
            fill_random();
            run_layer(n, 1'b0);
            check_layer($sformatf("rnd%0d", r), n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
